// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline stage registers: default widths,
// the ID/EX payload layout and a helper for sizing flattened payloads.
package mips_pipe_pkg;

  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned DEF_REG_AW  = 3;
  localparam int unsigned DEF_NUM_SRC = 1;

  // Field order here is the bit order used whenever a payload is flattened.
  typedef struct packed {
    logic [DEF_DATA_W-1:0]             rd_data;
    logic [DEF_NUM_SRC*DEF_REG_AW-1:0] rs;
    logic [DEF_REG_AW-1:0]             rd;
    logic                              reg_write;
    logic                              alu_src;
  } id_ex_payload_t;

  localparam int unsigned ID_EX_PAY_W = $bits(id_ex_payload_t);

  function automatic int unsigned id_ex_pay_w(input int unsigned data_w,
                                              input int unsigned reg_aw,
                                              input int unsigned num_src);
    return data_w + num_src * reg_aw + reg_aw + 2;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Payload-agnostic two-entry valid/ready buffer with flush; in_ready depends
// only on registered state, so it breaks the ready path between stages.
module pipe_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occupancy
);

  logic         main_valid;
  logic [W-1:0] main_data;
  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         in_fire;
  logic         head_free;

  assign in_ready  = reset & ~skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign occupancy = 2'(main_valid) + 2'(skid_valid);

  assign in_fire   = in_valid & in_ready;
  // Head is either empty or being consumed this cycle.
  assign head_free = ~main_valid | out_ready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (head_free) begin
      if (skid_valid) begin
        // in_ready is low while skid is full, so no new entry competes here.
        main_valid <= 1'b1;
        main_data  <= skid_data;
        skid_valid <= 1'b0;
      end else if (in_fire) begin
        main_valid <= 1'b1;
        main_data  <= in_data;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: valid/ready stage with stall, flush and optional
// two-entry skid buffer carrying decoded data, register indices and controls.
module id_ex_pipe_reg
  import mips_pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned REG_AW  = DEF_REG_AW,
  parameter int unsigned NUM_SRC = DEF_NUM_SRC,
  parameter int unsigned SKID    = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_rd_data,
  input  logic [NUM_SRC*REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0]         in_rd,
  input  logic                      in_reg_write,
  input  logic                      in_alu_src,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_rd_data,
  output logic [NUM_SRC*REG_AW-1:0] out_rs,
  output logic [REG_AW-1:0]         out_rd,
  output logic                      out_reg_write,
  output logic                      out_alu_src,
  output logic [1:0]                occupancy
);

  localparam int unsigned PAY_W = id_ex_pay_w(DATA_W, REG_AW, NUM_SRC);

  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] out_pay;
  logic             head_reg_write;

  // Same field order as id_ex_payload_t, scaled to this instance's widths.
  assign in_pay = {in_rd_data, in_rs, in_rd, in_reg_write, in_alu_src};
  assign {out_rd_data, out_rs, out_rd, head_reg_write, out_alu_src} = out_pay;

  // A bubble, including a flushed stale payload, never writes the register file.
  assign out_reg_write = head_reg_write & out_valid;

  generate
    if (SKID != 0) begin : g_skid
      pipe_skid_buf #(
        .W (PAY_W)
      ) u_buf (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pay),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_pay),
        .occupancy (occupancy)
      );
    end else begin : g_single
      logic             ent_valid;
      logic [PAY_W-1:0] ent_data;

      // Accept when empty or when the held entry leaves this cycle.
      assign in_ready  = reset & (~ent_valid | out_ready);
      assign out_valid = ent_valid;
      assign out_pay   = ent_data;
      assign occupancy = 2'(ent_valid);

      always_ff @(posedge clock) begin
        if (!reset) begin
          ent_valid <= 1'b0;
          ent_data  <= '0;
        end else if (flush) begin
          ent_valid <= 1'b0;
        end else if (in_valid & in_ready) begin
          ent_valid <= 1'b1;
          ent_data  <= in_pay;
        end else if (out_ready) begin
          ent_valid <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: a default SKID=1 instance and a wide
// SKID=0, NUM_SRC=2 instance sharing clock, reset and flush.
module tb_id_ex_pipe_reg;

  logic clock;
  logic reset;
  logic flush;

  // Instance A: DATA_W=8, REG_AW=3, NUM_SRC=1, SKID=1
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0] a_in_rd_data, a_out_rd_data;
  logic [2:0] a_in_rs, a_out_rs, a_in_rd, a_out_rd;
  logic       a_in_reg_write, a_out_reg_write, a_in_alu_src, a_out_alu_src;
  logic [1:0] a_occupancy;

  // Instance B: DATA_W=16, REG_AW=3, NUM_SRC=2, SKID=0
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [15:0] b_in_rd_data, b_out_rd_data;
  logic [5:0]  b_in_rs, b_out_rs;
  logic [2:0]  b_in_rd, b_out_rd;
  logic        b_in_reg_write, b_out_reg_write, b_in_alu_src, b_out_alu_src;
  logic [1:0]  b_occupancy;

  int pass_cnt;
  int total_cnt;

  id_ex_pipe_reg #(.DATA_W(8), .REG_AW(3), .NUM_SRC(1), .SKID(1)) dut_a (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_rd_data(a_in_rd_data), .in_rs(a_in_rs), .in_rd(a_in_rd),
    .in_reg_write(a_in_reg_write), .in_alu_src(a_in_alu_src),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_rd_data(a_out_rd_data), .out_rs(a_out_rs), .out_rd(a_out_rd),
    .out_reg_write(a_out_reg_write), .out_alu_src(a_out_alu_src),
    .occupancy(a_occupancy)
  );

  id_ex_pipe_reg #(.DATA_W(16), .REG_AW(3), .NUM_SRC(2), .SKID(0)) dut_b (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_rd_data(b_in_rd_data), .in_rs(b_in_rs), .in_rd(b_in_rd),
    .in_reg_write(b_in_reg_write), .in_alu_src(b_in_alu_src),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_rd_data(b_out_rd_data), .out_rs(b_out_rs), .out_rd(b_out_rd),
    .out_reg_write(b_out_reg_write), .out_alu_src(b_out_alu_src),
    .occupancy(b_occupancy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    a_in_valid = 1'b1; a_in_rd_data = 8'h99; a_in_reg_write = 1'b1;
    b_in_valid = 1'b1; b_in_rd_data = 16'h9999; b_in_reg_write = 1'b1;
    step();
    step();
    total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL reset_a_out_valid: got %b want 0", a_out_valid); else pass_cnt++;
    total_cnt++; if (a_out_rd_data !== 8'h00) $display("FAIL reset_a_rd_data: got %h want 00", a_out_rd_data); else pass_cnt++;
    total_cnt++; if (a_out_reg_write !== 1'b0) $display("FAIL reset_a_reg_write: got %b want 0", a_out_reg_write); else pass_cnt++;
    total_cnt++; if (a_occupancy !== 2'd0) $display("FAIL reset_a_occupancy: got %0d want 0", a_occupancy); else pass_cnt++;
    total_cnt++; if (a_in_ready !== 1'b0) $display("FAIL reset_a_in_ready: got %b want 0", a_in_ready); else pass_cnt++;
    total_cnt++; if (b_out_valid !== 1'b0) $display("FAIL reset_b_out_valid: got %b want 0", b_out_valid); else pass_cnt++;
    total_cnt++; if (b_out_rd_data !== 16'h0000) $display("FAIL reset_b_rd_data: got %h want 0000", b_out_rd_data); else pass_cnt++;
    total_cnt++; if (b_in_ready !== 1'b0) $display("FAIL reset_b_in_ready: got %b want 0", b_in_ready); else pass_cnt++;
    reset = 1'b1;
    a_in_valid = 1'b0; a_in_reg_write = 1'b0;
    b_in_valid = 1'b0; b_in_reg_write = 1'b0;
    step();
    total_cnt++; if (a_in_ready !== 1'b1) $display("FAIL post_reset_a_in_ready: got %b want 1", a_in_ready); else pass_cnt++;
    total_cnt++; if (b_in_ready !== 1'b1) $display("FAIL post_reset_b_in_ready: got %b want 1", b_in_ready); else pass_cnt++;
    total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL post_reset_a_out_valid: got %b want 0", a_out_valid); else pass_cnt++;
  endtask

  task automatic test_streaming();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    a_out_ready = 1'b1;
    a_in_valid = 1'b1;
    a_in_rd_data = vals[0];
    a_in_rs = 3'd1; a_in_rd = 3'd2; a_in_alu_src = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++; if (a_out_valid !== 1'b1) $display("FAIL stream_valid_%0d: got %b want 1", i, a_out_valid); else pass_cnt++;
      total_cnt++; if (a_out_rd_data !== vals[i]) $display("FAIL stream_data_%0d: got %h want %h", i, a_out_rd_data, vals[i]); else pass_cnt++;
      if (i < 2) a_in_rd_data = vals[i+1];
      else a_in_valid = 1'b0;
    end
    total_cnt++; if (a_out_rs !== 3'd1 || a_out_rd !== 3'd2 || a_out_alu_src !== 1'b1)
      $display("FAIL stream_fields: got rs=%0d rd=%0d alu=%b want 1 2 1", a_out_rs, a_out_rd, a_out_alu_src); else pass_cnt++;
    step();
    total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL stream_drain_valid: got %b want 0", a_out_valid); else pass_cnt++;
    total_cnt++; if (a_occupancy !== 2'd0) $display("FAIL stream_drain_occ: got %0d want 0", a_occupancy); else pass_cnt++;
  endtask

  task automatic test_back_pressure();
    a_out_ready = 1'b0;
    a_in_valid = 1'b1;
    a_in_rd_data = 8'hA5;
    step();
    total_cnt++; if (a_occupancy !== 2'd1) $display("FAIL bp_occ1: got %0d want 1", a_occupancy); else pass_cnt++;
    total_cnt++; if (a_in_ready !== 1'b1) $display("FAIL bp_ready1: got %b want 1", a_in_ready); else pass_cnt++;
    a_in_rd_data = 8'h5A;
    step();
    a_in_valid = 1'b0;
    total_cnt++; if (a_occupancy !== 2'd2) $display("FAIL bp_occ2: got %0d want 2", a_occupancy); else pass_cnt++;
    total_cnt++; if (a_in_ready !== 1'b0) $display("FAIL bp_ready_full: got %b want 0", a_in_ready); else pass_cnt++;
    total_cnt++; if (a_out_rd_data !== 8'hA5) $display("FAIL bp_head: got %h want a5", a_out_rd_data); else pass_cnt++;
    step();
    total_cnt++; if (a_out_rd_data !== 8'hA5 || a_out_valid !== 1'b1) $display("FAIL bp_stall_hold: got %h/%b want a5/1", a_out_rd_data, a_out_valid); else pass_cnt++;
    a_out_ready = 1'b1;
    step();
    total_cnt++; if (a_out_rd_data !== 8'h5A || a_out_valid !== 1'b1) $display("FAIL bp_drain2: got %h/%b want 5a/1", a_out_rd_data, a_out_valid); else pass_cnt++;
    total_cnt++; if (a_occupancy !== 2'd1) $display("FAIL bp_drain_occ: got %0d want 1", a_occupancy); else pass_cnt++;
    total_cnt++; if (a_in_ready !== 1'b1) $display("FAIL bp_ready_back: got %b want 1", a_in_ready); else pass_cnt++;
    step();
    total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL bp_empty: got %b want 0", a_out_valid); else pass_cnt++;
  endtask

  task automatic test_flush();
    a_out_ready = 1'b0;
    a_in_valid = 1'b1;
    a_in_reg_write = 1'b1;
    a_in_rd_data = 8'h01;
    step();
    a_in_rd_data = 8'h02;
    step();
    total_cnt++; if (a_occupancy !== 2'd2) $display("FAIL flush_pre_occ: got %0d want 2", a_occupancy); else pass_cnt++;
    flush = 1'b1;
    a_in_rd_data = 8'h77;
    step();
    flush = 1'b0;
    a_in_valid = 1'b0;
    a_in_reg_write = 1'b0;
    total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", a_out_valid); else pass_cnt++;
    total_cnt++; if (a_occupancy !== 2'd0) $display("FAIL flush_occ: got %0d want 0", a_occupancy); else pass_cnt++;
    total_cnt++; if (a_out_reg_write !== 1'b0) $display("FAIL flush_reg_write: got %b want 0", a_out_reg_write); else pass_cnt++;
    a_out_ready = 1'b1;
    // Flush while the stage is ready: the simultaneous accept must be dropped.
    flush = 1'b1;
    a_in_valid = 1'b1;
    a_in_rd_data = 8'h77;
    step();
    flush = 1'b0;
    a_in_valid = 1'b0;
    total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL flush_drop_valid: got %b want 0", a_out_valid); else pass_cnt++;
    step();
    total_cnt++; if (a_out_valid !== 1'b0 || a_occupancy !== 2'd0) $display("FAIL flush_drop_later: got %b/%0d want 0/0", a_out_valid, a_occupancy); else pass_cnt++;
  endtask

  task automatic test_bubble_gating();
    a_out_ready = 1'b0;
    a_in_valid = 1'b1;
    a_in_reg_write = 1'b1;
    a_in_rd_data = 8'h3C;
    step();
    a_in_valid = 1'b0;
    total_cnt++; if (a_out_reg_write !== 1'b1) $display("FAIL gate_pre: got %b want 1", a_out_reg_write); else pass_cnt++;
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (a_out_reg_write !== 1'b0) $display("FAIL gate_post_%0d: got %b want 0", i, a_out_reg_write); else pass_cnt++;
      step();
    end
    a_in_reg_write = 1'b0;
  endtask

  task automatic test_skid0_wide();
    b_out_ready = 1'b0;
    b_in_valid = 1'b1;
    b_in_rs = 6'b101_011;
    b_in_rd_data = 16'hBEEF;
    b_in_rd = 3'd5;
    b_in_alu_src = 1'b1;
    #1;
    total_cnt++; if (b_in_ready !== 1'b1) $display("FAIL s0_ready_empty: got %b want 1", b_in_ready); else pass_cnt++;
    step();
    b_in_valid = 1'b0;
    #1;
    total_cnt++; if (b_in_ready !== 1'b0) $display("FAIL s0_ready_stall: got %b want 0", b_in_ready); else pass_cnt++;
    b_out_ready = 1'b1;
    #1;
    total_cnt++; if (b_in_ready !== 1'b1) $display("FAIL s0_ready_comb: got %b want 1", b_in_ready); else pass_cnt++;
    b_out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (b_out_rs !== 6'b101_011 || b_out_rd_data !== 16'hBEEF || b_out_valid !== 1'b1)
        $display("FAIL s0_hold_%0d: got rs=%b data=%h v=%b want 101011 beef 1", i, b_out_rs, b_out_rd_data, b_out_valid); else pass_cnt++;
      total_cnt++; if (b_occupancy !== 2'd1) $display("FAIL s0_occ_%0d: got %0d want 1", i, b_occupancy); else pass_cnt++;
      step();
    end
    // Same-cycle drain and accept replaces the single entry.
    b_out_ready = 1'b1;
    b_in_valid = 1'b1;
    b_in_rs = 6'b010_110;
    b_in_rd_data = 16'h1234;
    step();
    b_in_valid = 1'b0;
    total_cnt++; if (b_out_rd_data !== 16'h1234 || b_out_rs !== 6'b010_110) $display("FAIL s0_replace: got %h/%b want 1234/010110", b_out_rd_data, b_out_rs); else pass_cnt++;
    total_cnt++; if (b_occupancy !== 2'd1) $display("FAIL s0_replace_occ: got %0d want 1", b_occupancy); else pass_cnt++;
    step();
    total_cnt++; if (b_out_valid !== 1'b0 || b_occupancy !== 2'd0) $display("FAIL s0_empty: got %b/%0d want 0/0", b_out_valid, b_occupancy); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    reset = 1'b0;
    flush = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_rd_data = '0; a_in_rs = '0;
    a_in_rd = '0; a_in_reg_write = 1'b0; a_in_alu_src = 1'b0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_rd_data = '0; b_in_rs = '0;
    b_in_rd = '0; b_in_reg_write = 1'b0; b_in_alu_src = 1'b0;
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_bubble_gating();
    test_skid0_wide();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
Parametrised ID/EX pipeline register for the pipelined MIPS core. It replaces the free-running ID/EX latch with a valid/ready stage that supports stall back-pressure, flush (bubble insertion) and an optional two-entry skid buffer. It carries the decoded destination data, source/destination register indices and control bits from decode to execute. Width and source-count are generic so the same block serves the 8-bit core and wider variants.

Parameters:
DATA_W, 8, width of the register data field (rd_data)
REG_AW, 3, width of one register index
NUM_SRC, 1, number of source register indices carried (rs field is NUM_SRC*REG_AW bits)
SKID, 1, 1 = two-entry skid buffer (fully registered in_ready); 0 = single entry, in_ready combinational from out_ready

Ports:
clock  in  1  rising-edge clock; the block's only clock
reset  in  1  synchronous, active-low reset, sampled on the rising edge of clock
flush  in  1  discard all held entries this cycle (branch/hazard squash)
in_valid  in  1  decode stage presents a valid instruction
in_ready  out  1  stage can accept this cycle
in_rd_data  in  DATA_W  destination/operand data
in_rs  in  NUM_SRC*REG_AW  source register indices
in_rd  in  REG_AW  destination register index
in_reg_write  in  1  register-file write enable
in_alu_src  in  1  ALU operand-B select
out_valid  out  1  head entry valid toward execute
out_ready  in  1  execute stage accepts head entry
out_rd_data  out  DATA_W  head payload
out_rs  out  NUM_SRC*REG_AW  head payload
out_rd  out  REG_AW  head payload
out_reg_write  out  1  head reg_write AND out_valid (a bubble never writes)
out_alu_src  out  1  head payload
occupancy  out  2  entries held: 0, 1 or 2 (2 only when SKID=1)

Behaviour:
- Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready; all state updates on rising clock.
- Reset (reset==0 at an edge): both entries invalid, all payload registers 0, occupancy 0; reset overrides flush and in_fire. While reset is low, in_ready is 0. First accept is possible on the first edge with reset high.
- After reset, every output is 0 except in_ready, which is 1.
- Latency: an accepted instruction appears on out_* the cycle after in_fire; one instruction per cycle of throughput when out_ready stays high.
- SKID=1: entries are main (head) and skid. in_ready = reset & !skid_valid (registered).
  - in_fire with head empty or head leaving (out_fire): load main.
  - in_fire while head held (out_valid & !out_ready): load skid.
  - out_fire with skid_valid: skid moves to main. With a simultaneous in_fire this cannot happen, because in_ready is 0 when skid is full.
- SKID=0: single entry; in_ready = reset & (!out_valid | out_ready); same-cycle out_fire and in_fire replace the entry.
- Stall: out_ready low holds the head payload and out_valid stable, with no change on any out_* signal.
- Flush (reset high): at the edge, all entries become invalid and occupancy becomes 0. An in_fire in the same cycle is dropped. Payload registers may keep stale values, but out_reg_write is forced 0 by valid gating.
- occupancy = main_valid + skid_valid. It must never exceed 1 when SKID=0 or 2 when SKID=1.
- Payloads are stored verbatim with no width conversion; in_rs is packed with source 0 in the LSBs.

Decomposition:
- Shared package mips_pipe_pkg: DATA_W/REG_AW defaults, and packed struct id_ex_payload_t {rd_data, rs, rd, reg_write, alu_src} used by every stage register.
- One natural sub-module, pipe_skid_buf: a generic payload-agnostic two-entry valid/ready buffer with flush. id_ex_pipe_reg instantiates it, or a single-entry register when SKID=0, and packs/unpacks the payload.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1 -> out_valid=0, out_* all 0, occupancy=0, in_ready=0. Release reset -> in_ready=1 on the next cycle.
- Streaming: out_ready=1, drive rd_data 0x11, 0x22, 0x33 on consecutive cycles -> out_rd_data shows 0x11, 0x22, 0x33 one cycle later each, with no gaps.
- Back-pressure (SKID=1): out_ready=0 with 0xA5 then 0x5A sent -> occupancy=2, in_ready=0, out holds 0xA5. Raise out_ready -> 0xA5 then 0x5A drain, and in_ready returns to 1.
- Flush: two entries held, assert flush with in_valid=1 and rd_data=0x77 -> next cycle out_valid=0, occupancy=0, out_reg_write=0, and 0x77 never appears.
- Bubble gating: an accepted entry with reg_write=1 is flushed -> out_reg_write=0 on every cycle after the flush.
- SKID=0, NUM_SRC=2, DATA_W=16: out_ready=0 -> in_ready drops combinationally. Send in_rs=6'b101_011 and data 0xBEEF -> out_rs=6'b101_011 and out_rd_data=0xBEEF, unchanged through a 3-cycle stall.
